alu_multicycle: RTL



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_shifter_iter.sv | 58 +++++
 rtl/alu_multicycle.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings, FSM state encoding and default datapath
// sizes shared by the ALU control decoder and the execution-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEF   = 64;
  localparam int unsigned ALU_SHAMT_W_DEF = 6;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LEFT      = 2'd0,
    SH_RIGHT_LOG = 2'd1,
    SH_RIGHT_ARI = 2'd2
  } alu_sh_dir_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter_iter.sv
// alu_shifter_iter: 1-bit-per-cycle shifter. Loaded with a non-zero shift
// amount on i_start; o_done is high during the cycle whose clock edge
// performs the final step, with o_data showing that final shifted value.
// Not instantiated when ALU_BARREL_SHIFT_EN is defined.
module alu_shifter_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH_DEF,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  alu_sh_dir_e        i_dir,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_data
);

  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  alu_sh_dir_e        r_dir;
  logic [WIDTH-1:0]   w_step;

  // One-bit step of the working register in the captured direction.
  always_comb begin
    w_step = r_work;
    case (r_dir)
      SH_LEFT:      w_step = {r_work[WIDTH-2:0], 1'b0};
      SH_RIGHT_LOG: w_step = {1'b0, r_work[WIDTH-1:1]};
      SH_RIGHT_ARI: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default:      w_step = r_work;
    endcase
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == SHAMT_W'(1));
  assign o_data = w_step;

  // Load on start, otherwise step and count down while work remains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_dir  <= SH_LEFT;
    end else if (i_start) begin
      r_work <= i_data;
      r_cnt  <= i_shamt;
      r_dir  <= i_dir;
    end else if (o_busy) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: execution-stage ALU with valid/ready on both sides.
// Non-shift ops finish in one cycle; shifts use an iterative shifter
// (latency shamt+1) unless ALU_BARREL_SHIFT_EN is defined, in which case a
// combinational barrel shifter gives latency 1 for every code.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH_DEF,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ill;
  logic               w_load;
  logic [WIDTH-1:0]   w_load_res;
  logic               w_load_ill;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt = op_b[SHAMT_W-1:0];

`ifndef ALU_BARREL_SHIFT_EN
  logic             w_sh_start;
  logic             w_sh_busy;
  logic             w_sh_done;
  logic [WIDTH-1:0] w_sh_data;
  alu_sh_dir_e      w_sh_dir;

  // Map the shift code to the shifter's direction select.
  always_comb begin
    w_sh_dir = SH_LEFT;
    if (alu_ctl == ALU_SRL)      w_sh_dir = SH_RIGHT_LOG;
    else if (alu_ctl == ALU_SRA) w_sh_dir = SH_RIGHT_ARI;
  end

  alu_shifter_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_sh_start),
    .i_dir   (w_sh_dir),
    .i_data  (op_a),
    .i_shamt (w_shamt),
    .o_busy  (w_sh_busy),
    .o_done  (w_sh_done),
    .o_data  (w_sh_data)
  );

  assign in_ready = (r_state == ST_IDLE) && !w_sh_busy;
`else
  assign in_ready = (r_state == ST_IDLE);
`endif

  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

  // Single-cycle result for the presented request.
  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    case (alu_ctl)
      ALU_AND:  w_alu_res = op_a & op_b;
      ALU_OR:   w_alu_res = op_a | op_b;
      ALU_ADD:  w_alu_res = op_a + op_b;
      ALU_XOR:  w_alu_res = op_a ^ op_b;
      ALU_SUB:  w_alu_res = op_a - op_b;
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:  w_alu_res = op_a << w_shamt;
      ALU_SRL:  w_alu_res = op_a >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(op_a) >>> w_shamt);
`else
      // Only shamt == 0 completes here; other amounts go to the shifter.
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = op_a;
`endif
      default:  w_alu_ill = 1'b1;
    endcase
  end

  // Next-state logic and result-register load selection.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_res  = w_alu_res;
    w_load_ill  = w_alu_ill;
`ifndef ALU_BARREL_SHIFT_EN
    w_sh_start  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift(alu_ctl) && (w_shamt != '0)) begin
            w_sh_start  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_DONE;
          end
`else
          w_load      = 1'b1;
          w_state_nxt = ST_DONE;
`endif
        end
      end
      ST_SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
        if (w_sh_done) begin
          w_load      = 1'b1;
          w_load_res  = w_sh_data;
          w_load_ill  = 1'b0;
          w_state_nxt = ST_DONE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Result/flag registers; held unchanged except when a result is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_result  <= w_load_res;
      r_zero    <= (w_load_res == '0);
      r_illegal <= w_load_ill;
    end
  end

endmodule
